// File: rtl/fcpu_pkg.sv
// Shared result-bus types for the ROB, reservation stations and the CDB arbiter.
package fcpu_pkg;

    localparam int RSV_ID_W = 6;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Small per-producer result FIFO feeding the CDB arbiter; clr empties it in one edge.
module cdb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;
        end
    end

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among N_REQ result producers,
// each buffered by its own small FIFO, with a registered broadcast output.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int GID_W      = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][CDB_W-1:0]   req_data,
    input  logic                          flush,
    output logic                          cdb_valid,
    output logic [CDB_W-1:0]              cdb,
    output logic [GID_W-1:0]              grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] full;
    logic [N_REQ-1:0] empty;
    logic [CDB_W-1:0] fifo_head  [N_REQ];
    logic [CNT_W-1:0] fifo_count [N_REQ];

    logic             grant_vld_p0;
    logic [GID_W-1:0] grant_id_p0;
    logic [GID_W-1:0] rr_next_p0;
    cdb_entry_t       grant_entry_p0;
    logic [GID_W-1:0] rr_ptr;
    logic [GID_W-1:0] scan_sel;
    int               scan_idx;
    logic             pending;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        // Ready depends on state only; a full FIFO refuses even while being popped.
        assign req_ready[g] = nrst & ~full[g];
        assign push[g]      = req_valid[g] & req_ready[g] & ~flush;
        assign pop[g]       = grant_vld_p0 & (grant_id_p0 == GID_W'(g)) & ~flush;

        cdb_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (CDB_W)
        ) u_fifo (
            .clk   (clk),
            .nrst  (nrst),
            .clr   (flush),
            .push  (push[g]),
            .din   (req_data[g]),
            .pop   (pop[g]),
            .dout  (fifo_head[g]),
            .count (fifo_count[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Stage p0: round-robin scan from rr_ptr over FIFOs holding entries before this edge.
    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_id_p0  = '0;
        scan_idx     = 0;
        scan_sel     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            scan_sel = GID_W'(scan_idx);
            if (!grant_vld_p0 && !empty[scan_sel]) begin
                grant_vld_p0 = 1'b1;
                grant_id_p0  = scan_sel;
            end
        end
    end

    assign grant_entry_p0 = cdb_entry_t'(fifo_head[grant_id_p0]);
    assign rr_next_p0     = (grant_id_p0 == GID_W'(N_REQ - 1)) ? '0 : grant_id_p0 + GID_W'(1);

    // Stage p1: registered broadcast; flush wins over any grant.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cdb_valid <= 1'b0;
            cdb       <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (grant_vld_p0) begin
            cdb_valid <= 1'b1;
            cdb       <= grant_entry_p0;
            grant_id  <= grant_id_p0;
            rr_ptr    <= rr_next_p0;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (fifo_count[i] != '0) pending = 1'b1;
        end
    end

    assign busy = cdb_valid | pending;

endmodule
